// File: rtl/display_scanner.sv
// HUB75 panel scanner: reads the frame buffer row by row, shifts one bit plane
// per pass, then latches it and lights it for base << plane clocks (binary-coded
// modulation).
//
// Fixed SHIFT entry pipeline latency: every SHIFT lasts 2*columns + 2 clk.
// The first two cycles fetch column 0 and load r/g/b ahead of the first pclk
// edge. A frame therefore runs
//   rows*depth*(2*columns + 2 + base) + base*rows*(2^depth - 1 - depth)
//   + 2*rows*depth clk
// when enable stays high.
//
// The frame end is decided on the last DISPLAY clock of the last plane of the
// last row. The edge that closes that clock raises frame_done and, if a flip is
// pending, toggles flip. A flip_req sampled on that same edge still counts.
//
//   state   | meaning
//   IDLE    | outputs quiet, waiting for enable
//   SHIFT   | stream one plane of the current row out on r/g/b with pclk
//   BLANK   | one clk gap after the last pclk edge, panel still dark
//   LATCH   | lat pulse, addr moves to the row just shifted
//   DISPLAY | oe_n low for base << plane clk

module display_scanner #(
  parameter int rows    = 8,
  parameter int columns = 32,
  parameter int depth   = 8,
  parameter int base    = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic                       flip_req_i,
  output logic                       flip_o,
  output logic [$clog2(rows)-1:0]    rrow_o,
  output logic [$clog2(columns)-1:0] rcol_o,
  input  logic [23:0]                rdata_i,
  output logic                       pclk_o,
  output logic                       r_o,
  output logic                       g_o,
  output logic                       b_o,
  output logic                       lat_o,
  output logic                       oe_n_o,
  output logic [$clog2(rows)-1:0]    addr_o,
  output logic                       frame_done_o
);

  localparam int RW = $clog2(rows);
  localparam int CW = $clog2(columns);
  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam int SW = $clog2(2 * columns + 2);
  localparam int DW = $clog2((base << (depth - 1)) + 1);

  typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DISPLAY} state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [PW-1:0] plane_q, plane_d;
  logic [SW-1:0] sc_q, sc_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          pend_q, pend_d;
  logic          flip_q, flip_d;
  logic [CW-1:0] rcol_q, rcol_d;
  logic          pclk_q, pclk_d;
  logic          r_q, r_d, g_q, g_d, b_q, b_d;
  logic          lat_q, lat_d;
  logic          oe_n_q, oe_n_d;
  logic [RW-1:0] addr_q, addr_d;
  logic          fd_q, fd_d;

  logic [7:0] chan_r, chan_g, chan_b;
  logic       shift_done, last_plane, last_row;

  assign chan_r     = rdata_i[23:16];
  assign chan_g     = rdata_i[15:8];
  assign chan_b     = rdata_i[7:0];
  assign shift_done = (sc_q == SW'(2 * columns + 1));
  assign last_plane = (plane_q == PW'(depth - 1));
  assign last_row   = (row_q == RW'(rows - 1));

  // Next state, counters and next values of every registered output.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    plane_d = plane_q;
    sc_d    = sc_q;
    dcnt_d  = dcnt_q;
    pend_d  = pend_q | flip_req_i;
    flip_d  = flip_q;
    rcol_d  = rcol_q;
    pclk_d  = 1'b0;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    lat_d   = 1'b0;
    oe_n_d  = 1'b1;
    addr_d  = addr_q;
    fd_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = SHIFT;
          sc_d    = '0;
          row_d   = '0;
          plane_d = '0;
          rcol_d  = '0;
        end
      end
      SHIFT: begin
        sc_d = sc_q + SW'(1);
        // Odd cycles capture the pixel fetched one clk earlier and move rcol on.
        if (sc_q[0] && !shift_done) begin
          r_d    = chan_r[plane_q];
          g_d    = chan_g[plane_q];
          b_d    = chan_b[plane_q];
          rcol_d = (rcol_q == CW'(columns - 1)) ? '0 : rcol_q + CW'(1);
        end
        // Data settles for one clk before pclk rises.
        pclk_d = !sc_q[0] && (sc_q != '0);
        if (shift_done) state_d = BLANK;
      end
      BLANK: begin
        state_d = LATCH;
        lat_d   = 1'b1;
        addr_d  = row_q;
      end
      LATCH: begin
        state_d = DISPLAY;
        oe_n_d  = 1'b0;
        dcnt_d  = (DW'(base) << plane_q) - DW'(1);
      end
      DISPLAY: begin
        if (dcnt_q != '0) begin
          dcnt_d = dcnt_q - DW'(1);
          oe_n_d = 1'b0;
        end else begin
          state_d = SHIFT;
          sc_d    = '0;
          if (!last_plane) begin
            plane_d = plane_q + PW'(1);
          end else begin
            plane_d = '0;
            if (!last_row) begin
              row_d = row_q + RW'(1);
            end else begin
              row_d   = '0;
              fd_d    = 1'b1;
              pend_d  = 1'b0;
              flip_d  = flip_q ^ (pend_q | flip_req_i);
              state_d = enable_i ? SHIFT : IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      row_q   <= '0;
      plane_q <= '0;
      sc_q    <= '0;
      dcnt_q  <= '0;
      pend_q  <= 1'b0;
      flip_q  <= 1'b0;
      rcol_q  <= '0;
      pclk_q  <= 1'b0;
      r_q     <= 1'b0;
      g_q     <= 1'b0;
      b_q     <= 1'b0;
      lat_q   <= 1'b0;
      oe_n_q  <= 1'b1;
      addr_q  <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      plane_q <= plane_d;
      sc_q    <= sc_d;
      dcnt_q  <= dcnt_d;
      pend_q  <= pend_d;
      flip_q  <= flip_d;
      rcol_q  <= rcol_d;
      pclk_q  <= pclk_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      lat_q   <= lat_d;
      oe_n_q  <= oe_n_d;
      addr_q  <= addr_d;
      fd_q    <= fd_d;
    end
  end

  assign flip_o       = flip_q;
  assign rrow_o       = row_q;
  assign rcol_o       = rcol_q;
  assign pclk_o       = pclk_q;
  assign r_o          = r_q;
  assign g_o          = g_q;
  assign b_o          = b_q;
  assign lat_o        = lat_q;
  assign oe_n_o       = oe_n_q;
  assign addr_o       = addr_q;
  assign frame_done_o = fd_q;

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner: random double-buffered frame memory, frame-level
// reference model, and directed flip / enable / reset sequences.
module tb_display_scanner;
  localparam int ROWS = 8;
  localparam int COLS = 32;
  localparam int D    = 8;
  localparam int BASE = 4;
  localparam int FL   = ROWS*D*(2*COLS + 2 + BASE) + BASE*ROWS*((1 << D) - 1 - D) + 2*ROWS*D;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        flip_req = 1'b0;
  logic        flip;
  logic [2:0]  rrow;
  logic [4:0]  rcol;
  logic [23:0] rdata = '0;
  logic        pclk, r, g, b, lat, oe_n, fd;
  logic [2:0]  addr;

  always #5 clk = ~clk;

  display_scanner #(.rows(ROWS), .columns(COLS), .depth(D), .base(BASE)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .flip_req_i(flip_req),
    .flip_o(flip), .rrow_o(rrow), .rcol_o(rcol), .rdata_i(rdata),
    .pclk_o(pclk), .r_o(r), .g_o(g), .b_o(b), .lat_o(lat), .oe_n_o(oe_n),
    .addr_o(addr), .frame_done_o(fd)
  );

  logic [23:0] mem [2][ROWS][COLS];
  always @(posedge clk) rdata <= mem[flip][rrow][rcol];

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  typedef struct { int plane; int oe_low; } dur_vec_t;
  typedef struct { string name; int exp; } rst_vec_t;
  dur_vec_t dur_tab[D];
  rst_vec_t rst_tab[11];

  function automatic int out_val(int i);
    case (i)
      0: return int'(flip);
      1: return int'(rrow);
      2: return int'(rcol);
      3: return int'(pclk);
      4: return int'(r);
      5: return int'(g);
      6: return int'(b);
      7: return int'(lat);
      8: return int'(oe_n);
      9: return int'(addr);
      10: return int'(fd);
      default: return -1;
    endcase
  endfunction

  // Frame-level reference model, sampled on the falling edge.
  bit exp_flip = 0, pend = 0, have_prev = 0, prev_en = 0, exp_idle = 0, prev_pclk = 0;
  int edge_cnt = 0, disp_idx = 0, lat_idx = 0, oe_run = 0, frame_cyc = 0;
  int prow, ppl, pcol;
  logic [23:0] px;

  always @(negedge clk) begin
    if (rst) begin
      exp_flip = 0; pend = 0; have_prev = 0; exp_idle = 0; prev_pclk = 0;
      edge_cnt = 0; disp_idx = 0; lat_idx = 0; oe_run = 0; frame_cyc = 0;
      prev_en = enable;
    end else begin
      frame_cyc++;
      if (pclk && !prev_pclk) begin
        prow = edge_cnt / (COLS*D);
        ppl  = (edge_cnt / COLS) % D;
        pcol = edge_cnt % COLS;
        if (prow < ROWS) begin
          px = mem[exp_flip][prow][pcol];
          chk("pixel_rgb", {r, g, b}, {px[16+ppl], px[8+ppl], px[ppl]});
          chk("rrow_during_shift", rrow, prow);
        end else begin
          chk("extra_pclk_edge", edge_cnt, ROWS*D*COLS - 1);
        end
        edge_cnt++;
      end
      prev_pclk = pclk;
      if (!oe_n) begin
        oe_run++;
        if (pclk || lat) chk("quiet_while_lit", {pclk, lat}, 0);
      end else if (oe_run > 0) begin
        chk("oe_low_len", oe_run, dur_tab[disp_idx % D].oe_low);
        disp_idx++;
        oe_run = 0;
      end
      if (lat) begin
        chk("lat_addr", addr, (lat_idx / D) % ROWS);
        lat_idx++;
      end
      if (exp_idle) chk("idle_quiet", {pclk, oe_n, lat, fd}, 4'b0100);
      if (fd) begin
        if (pend) exp_flip = ~exp_flip;
        pend = 0;
        chk("flip_at_frame_end", flip, exp_flip);
        chk("pclk_edges_per_frame", edge_cnt, ROWS*D*COLS);
        chk("lat_pulses_per_frame", lat_idx, ROWS*D);
        chk("oe_runs_per_frame", disp_idx, ROWS*D);
        if (have_prev) chk("frame_length", frame_cyc, FL);
        have_prev = prev_en;
        exp_idle  = !prev_en;
        edge_cnt = 0; disp_idx = 0; lat_idx = 0; frame_cyc = 0;
      end
      if (enable) exp_idle = 0;
      if (flip_req) pend = 1;
      prev_en = enable;
    end
  end

  task automatic wait_fd(input int max_cyc, input string tag);
    int k = 0;
    do begin @(posedge clk); #1; k++; end while (!fd && k < max_cyc);
    chk(tag, fd, 1);
  endtask

  task automatic check_reset_table();
    for (int i = 0; i < 11; i++) chk({"reset_", rst_tab[i].name}, out_val(i), rst_tab[i].exp);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int pclk_hi;
    for (int bf = 0; bf < 2; bf++)
      for (int rr = 0; rr < ROWS; rr++)
        for (int cc = 0; cc < COLS; cc++)
          mem[bf][rr][cc] = 24'($urandom);
    dur_tab[0] = '{0, 4};   dur_tab[1] = '{1, 8};   dur_tab[2] = '{2, 16};  dur_tab[3] = '{3, 32};
    dur_tab[4] = '{4, 64};  dur_tab[5] = '{5, 128}; dur_tab[6] = '{6, 256}; dur_tab[7] = '{7, 512};
    rst_tab[0] = '{"flip", 0};  rst_tab[1] = '{"rrow", 0};  rst_tab[2] = '{"rcol", 0};
    rst_tab[3] = '{"pclk", 0};  rst_tab[4] = '{"r", 0};     rst_tab[5] = '{"g", 0};
    rst_tab[6] = '{"b", 0};     rst_tab[7] = '{"lat", 0};   rst_tab[8] = '{"oe_n", 1};
    rst_tab[9] = '{"addr", 0};  rst_tab[10] = '{"frame_done", 0};

    // Power-on reset.
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_table();
    rst = 0;
    enable = 1;

    // Three requests inside one frame give a single toggle at its end.
    repeat (3) begin
      repeat ($urandom_range(200, 3000)) @(posedge clk);
      #1 flip_req = 1;
      @(posedge clk);
      #1 flip_req = 0;
    end
    wait_fd(2*FL, "frame_a_done");
    chk("flip_after_three_req", flip, 1);

    // No requests: no toggle at the next frame end.
    wait_fd(FL + 10, "frame_b_done");
    chk("flip_without_req", flip, 1);

    // Request sampled on the frame-end edge takes effect there.
    repeat (FL - 1) @(posedge clk);
    #1 flip_req = 1;
    @(posedge clk);
    #1 flip_req = 0;
    chk("fd_coincident_req", fd, 1);
    chk("flip_coincident_req", flip, 0);

    // Reset during DISPLAY of row 5.
    k = 0;
    while (!(addr == 3'd5 && !oe_n) && k < FL) begin @(posedge clk); #1; k++; end
    chk("reach_row5_display", int'(k < FL), 1);
    rst = 1;
    @(posedge clk);
    #1;
    check_reset_table();
    rst = 0;
    k = 0;
    while (!lat && k < 200) begin @(posedge clk); #1; k++; end
    chk("first_lat_after_reset_seen", lat, 1);
    chk("first_addr_after_reset", addr, 0);

    // Sparse random requests, then enable dropped mid-frame.
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk);
      #1 flip_req = ($urandom_range(0, 299) == 0);
    end
    flip_req = 0;
    enable = 0;
    wait_fd(FL, "frame_e_done");
    pclk_hi = 0;
    repeat (100) begin
      @(posedge clk);
      #1 if (pclk) pclk_hi++;
    end
    chk("idle_pclk_edges", pclk_hi, 0);
    chk("idle_oe_n", oe_n, 1);
    chk("idle_no_frame_done", fd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter rows, default 8: number of panel scan rows, matching display_memory rows.
REQ-002 Parameter columns, default 32: pixels per row, matching display_memory columns.
REQ-003 Parameter depth, default 8: bit planes per colour channel; depth SHALL be at most 8.
REQ-004 Parameter base, default 4: display clocks for bit plane 0.
REQ-005 clk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-006 rst  input  1  synchronous reset, active-high.
REQ-007 enable  input  1  permits scanning; sampled only in IDLE and at frame end.
REQ-008 flip_req  input  1  upstream request to swap buffers at the next frame boundary.
REQ-009 flip  output  1  buffer select to display_memory; registered.
REQ-010 rrow  output  clog2(rows)  display_memory read row; registered.
REQ-011 rcol  output  clog2(columns)  display_memory read column; registered.
REQ-012 rdata  input  24  pixel from display_memory, valid 1 clk after rrow/rcol: [23:16]=R, [15:8]=G, [7:0]=B.
REQ-013 pclk, r, g, b, lat, oe_n  output  1 each  HUB75 shift clock, data, latch, active-low output enable; all registered.
REQ-014 addr  output  clog2(rows)  HUB75 row address; registered.
REQ-015 frame_done  output  1  one-cycle pulse at each frame end.

Function
REQ-016 States SHALL be IDLE, SHIFT, BLANK, LATCH, DISPLAY; IDLE->SHIFT when enable=1, with row=0, plane=0.
REQ-017 In SHIFT, exactly `columns` pclk rising edges SHALL occur, one column per 2 clk (1 clk low, 1 clk high), columns in order 0..columns-1.
REQ-018 At the pclk rising edge for column c, r/g/b SHALL equal rdata bits [16+p], [8+p], [p] of pixel (row, c), where p = current plane.
REQ-019 rcol SHALL be issued early enough to absorb the 1-clk rdata latency; no data bubbles within a shift.
REQ-020 oe_n SHALL be 1 during SHIFT, BLANK and LATCH; pclk SHALL be 0 outside SHIFT.
REQ-021 BLANK lasts 1 clk; LATCH lasts 1 clk with lat=1 and addr updated to the current row in that cycle; lat SHALL be 0 otherwise.
REQ-022 DISPLAY SHALL hold oe_n=0 for exactly base << p clk, then advance.
REQ-023 Advance: plane+1; after plane depth-1, plane=0 and row+1; after row rows-1 plus plane depth-1, a frame end occurs.
REQ-024 At frame end: frame_done=1 for 1 clk; if a flip is pending, flip toggles in that cycle and the pending flag clears; then -> SHIFT (row 0) if enable=1, else -> IDLE.
REQ-025 flip_req=1 in any cycle SHALL set a sticky pending flag; multiple requests within one frame SHALL cause a single toggle; a request coinciding with frame end SHALL take effect at that frame end.
REQ-026 flip and rrow SHALL not change during a frame except as stated; rrow SHALL equal the row being shifted.
REQ-027 Frame length SHALL be rows*depth*(2*columns + 2 + base) + base*rows*(2^depth - 1 - depth) clk, exact to within the fixed SHIFT entry pipeline latency, which SHALL be constant and documented in the RTL header.

Reset
REQ-028 rst=1 SHALL force, at the next edge: state IDLE, row=plane=0, pending=0, flip=0, rrow=rcol=0, addr=0, pclk=r=g=b=lat=0, oe_n=1, frame_done=0.
REQ-029 rst SHALL override any state mid-frame; the first post-reset frame SHALL start at row 0, plane 0.

Verification
REQ-030 Memory model filled with pixel (row,c) = {row,c}-derived pattern, e.g. 24'hA5C3<c>; enable=1 -> every pclk edge carries the correct bit for each (row, plane); 32 edges per shift.
REQ-031 rows=8, depth=8, base=4 -> oe_n low durations per row are 4,8,...,512 clk in order; lat pulses 64 per frame with addr 0..7 each repeated 8 times.
REQ-032 flip_req pulsed 3 times mid-frame -> flip toggles 0->1 exactly once, coincident with frame_done; no toggle at the following frame end.
REQ-033 flip_req asserted in the same cycle as frame_done -> flip toggles in that cycle.
REQ-034 enable dropped mid-frame -> frame completes, frame_done pulses, state IDLE, oe_n=1, no further pclk edges.
REQ-035 rst asserted during DISPLAY of row 5 -> all outputs at reset values next clk; after release with enable=1, first latched addr is 0.
